// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer
//   Front end for a pipelined multiply-add: streams (a,b) pairs into the MAC
//   one per cycle, feeds the running sum back on mac_c (zero on the first
//   pair of a vector), and holds each finished dot product until taken.
//   Optional feature macro: DOTPROD_LEN_CHECK_EN (per-vector length check
//   reported on out_len_err; tied low when undefined).
module dot_product_sequencer #(
  parameter int IN_WIDTH  = 10,
  parameter int ACC_WIDTH = 24,
  parameter int LATENCY   = 2,
  parameter int CNT_WIDTH = 8,
  parameter int VEC_LEN   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_a,
  input  logic [IN_WIDTH-1:0]  in_b,
  input  logic                 in_last,
  output logic                 mac_enable,
  output logic                 mac_in_ready,
  output logic [IN_WIDTH-1:0]  mac_a,
  output logic [IN_WIDTH-1:0]  mac_b,
  output logic [ACC_WIDTH-1:0] mac_c,
  input  logic [ACC_WIDTH-1:0] mac_res,
  input  logic                 mac_out_ready,
  input  logic                 mac_early_out_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_len_err
);

  logic                 stall;
  logic                 accept;
  logic                 first_in;
  logic                 last_in;
  logic                 first_fin;
  logic                 last_fin;
  logic                 complete;
  logic                 first_pending_q, first_pending_d;
  logic [LATENCY:0]     last_sr_q, last_sr_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;

  if (LATENCY < 0 || LATENCY > 4 || CNT_WIDTH < 1 || VEC_LEN < 1) begin : g_param_check
    $error("dot_product_sequencer: illegal parameter combination");
  end

  // A held result that is not being taken freezes the MAC and the tag pipes.
  assign stall        = out_valid_q & ~out_ready;
  assign mac_enable   = ~stall & ~reset;
  assign in_ready     = mac_enable;
  assign accept       = in_valid & mac_enable;
  assign mac_in_ready = accept;
  assign mac_a        = in_a;
  assign mac_b        = in_b;

  // Tags only exist for slots that actually carry an issued pair.
  assign first_in = accept & first_pending_q;
  assign last_in  = accept & in_last;

  // Next accepted pair opens a new vector after reset or after a last pair.
  always_comb begin
    first_pending_d = first_pending_q;
    if (accept) begin
      first_pending_d = in_last;
    end
  end

  // Register the first-pending flag; reset arms it.
  always_ff @(posedge clk) begin
    if (reset) first_pending_q <= 1'b1;
    else       first_pending_q <= first_pending_d;
  end

  // First tag travels LATENCY stages to meet mac_early_out_ready.
  if (LATENCY == 0) begin : g_first_live
    assign first_fin = first_in;
  end else begin : g_first_pipe
    logic [LATENCY-1:0] first_sr_q, first_sr_d;

    // Shift the first tag only while the MAC advances.
    always_comb begin
      first_sr_d = first_sr_q;
      if (mac_enable) begin
        first_sr_d[0] = first_in;
        for (int i = 1; i < LATENCY; i++) begin
          first_sr_d[i] = first_sr_q[i-1];
        end
      end
    end

    // Register the first-tag pipe.
    always_ff @(posedge clk) begin
      if (reset) first_sr_q <= '0;
      else       first_sr_q <= first_sr_d;
    end

    assign first_fin = first_sr_q[LATENCY-1];
  end

  // Last tag runs one stage deeper so it lines up with mac_out_ready,
  // when mac_res already holds the finished sum.
  always_comb begin
    last_sr_d = last_sr_q;
    if (mac_enable) begin
      last_sr_d[0] = last_in;
      for (int i = 1; i <= LATENCY; i++) begin
        last_sr_d[i] = last_sr_q[i-1];
      end
    end
  end

  // Register the last-tag pipe.
  always_ff @(posedge clk) begin
    if (reset) last_sr_q <= '0;
    else       last_sr_q <= last_sr_d;
  end

  assign last_fin = last_sr_q[LATENCY];

  // The first product of a vector adds to zero; later ones add to the sum.
  assign mac_c = (mac_early_out_ready & first_fin) ? '0 : mac_res;

  // Gated by mac_enable: a frozen pipe must not re-fire a completion that
  // sits at the final stage while an earlier result is still held.
  assign complete = mac_enable & mac_out_ready & last_fin;

  // Result holding register: a completion loads, a take with no new
  // completion empties it. Load wins so a take and a following
  // single-element vector completing together do not drop the new result.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (complete) begin
      out_valid_d = 1'b1;
      out_data_d  = mac_res;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Register the result holding stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef DOTPROD_LEN_CHECK_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH:0]   cnt_next;
  logic                 err_in;
  logic [LATENCY:0]     err_sr_q, err_sr_d;
  logic                 len_err_q, len_err_d;

  assign cnt_next = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
  // The verdict is formed at the last pair and carried with it, since the
  // counter already belongs to the next vector by the time it completes.
  assign err_in   = last_in & (cnt_next != (CNT_WIDTH+1)'(VEC_LEN));

  // Count accepted pairs; clear after the last pair of each vector.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = in_last ? '0 : cnt_next[CNT_WIDTH-1:0];
    end
  end

  // Shift the length verdict alongside the last tag.
  always_comb begin
    err_sr_d = err_sr_q;
    if (mac_enable) begin
      err_sr_d[0] = err_in;
      for (int i = 1; i <= LATENCY; i++) begin
        err_sr_d[i] = err_sr_q[i-1];
      end
    end
  end

  // Capture the verdict together with out_data.
  always_comb begin
    len_err_d = len_err_q;
    if (complete) begin
      len_err_d = err_sr_q[LATENCY];
    end
  end

  // Register counter, verdict pipe and reported error.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      err_sr_q  <= '0;
      len_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      err_sr_q  <= err_sr_d;
      len_err_q <= len_err_d;
    end
  end

  assign out_len_err = len_err_q;
`else
  assign out_len_err = 1'b0;
`endif

endmodule
